// File: rtl/axi4_lite_slave_write_pkg.sv
// Shared AXI4-Lite definitions for the write-slave path.
//   RESP_OKAY / RESP_SLVERR : BRESP encodings
//   wr_state_e              : write-slave FSM states
//   DATA_WIDTH / STRB_WIDTH : fixed 32-bit data, 4 byte strobes
package axi4_lite_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned STRB_WIDTH = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HAVE_AW = 2'd1,
        HAVE_W  = 2'd2,
        RESP    = 2'd3
    } wr_state_e;

endpackage

// File: rtl/axi4_lite_slave_write_if.sv
// AXI4-Lite write channels (AW, W, B) as seen between a master and the
// write slave.
//   master modport : drives AW/W payload + valids and BREADY
//   slave modport  : drives AWREADY, WREADY, BVALID, BRESP
interface axi4_lite_slave_write_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                                 AWVALID;
    logic                                 AWREADY;
    logic [ADDR_WIDTH-1:0]                AWADDR;
    logic [2:0]                           AWPROT;
    logic                                 WVALID;
    logic                                 WREADY;
    logic [axi4_lite_pkg::DATA_WIDTH-1:0] WDATA;
    logic [axi4_lite_pkg::STRB_WIDTH-1:0] WSTRB;
    logic                                 BVALID;
    logic                                 BREADY;
    logic [1:0]                           BRESP;

    modport master (
        output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
        input  AWREADY, WREADY, BVALID, BRESP
    );

    modport slave (
        input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
        output AWREADY, WREADY, BVALID, BRESP
    );
endinterface

// File: rtl/axi4_lite_slave_write.sv
// AXI4-Lite write slave. Captures AW and W independently (any order),
// commits a single-cycle strobed write to an external register bank and
// returns OKAY (in range) or SLVERR (word index >= NUM_REGS) on B.
//   ACLK, ARESETn : clock, asynchronous active-low reset
//   bus           : AXI4-Lite write channels (slave modport)
//   REG_WEN       : one-cycle write pulse (in range, nonzero strobe)
//   REG_IDX       : register index (captured index truncated)
//   REG_WDATA     : write data, held until the next commit
//   REG_WSTRB     : byte enables, held until the next commit
module axi4_lite_slave_write
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REGS   = 16
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    axi4_lite_slave_write_if.slave     bus,
    output logic                       REG_WEN,
    output logic [$clog2(NUM_REGS)-1:0] REG_IDX,
    output logic [DATA_WIDTH-1:0]      REG_WDATA,
    output logic [STRB_WIDTH-1:0]      REG_WSTRB
);

    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int AIDX_W = ADDR_WIDTH - 2;

    wr_state_e               state_q, state_d;
    logic                    awready_q, awready_d;
    logic                    wready_q, wready_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [AIDX_W-1:0]       aw_idx_q, aw_idx_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic                    reg_wen_q, reg_wen_d;
    logic [IDX_W-1:0]        reg_idx_q, reg_idx_d;
    logic [DATA_WIDTH-1:0]   reg_wdata_q, reg_wdata_d;
    logic [STRB_WIDTH-1:0]   reg_wstrb_q, reg_wstrb_d;

    logic                    aw_hs, w_hs, commit, out_of_range;
    logic [AIDX_W-1:0]       eff_idx;
    logic [DATA_WIDTH-1:0]   eff_wdata;
    logic [STRB_WIDTH-1:0]   eff_wstrb;

    // AWPROT and the byte-offset address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{bus.AWPROT, bus.AWADDR[1:0]};

    assign aw_hs = bus.AWVALID & awready_q;
    assign w_hs  = bus.WVALID & wready_q;

    // On the commit edge the last channel is still on the bus, so the
    // committed beat is taken from the bus for that channel and from the
    // capture registers for the other.
    assign eff_idx      = aw_hs ? bus.AWADDR[ADDR_WIDTH-1:2] : aw_idx_q;
    assign eff_wdata    = w_hs ? bus.WDATA : wdata_q;
    assign eff_wstrb    = w_hs ? bus.WSTRB : wstrb_q;
    assign out_of_range = 32'(eff_idx) >= 32'(NUM_REGS);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (aw_hs && w_hs) state_d = RESP;
                else if (aw_hs)    state_d = HAVE_AW;
                else if (w_hs)     state_d = HAVE_W;
            end
            HAVE_AW: if (w_hs)  state_d = RESP;
            HAVE_W:  if (aw_hs) state_d = RESP;
            RESP:    if (bus.BREADY && bvalid_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        commit = (state_q != RESP) && (state_d == RESP);

        // Readies follow the next state so a channel closes on the very
        // edge that completes its handshake.
        awready_d = (state_d == IDLE) || (state_d == HAVE_W);
        wready_d  = (state_d == IDLE) || (state_d == HAVE_AW);
        bvalid_d  = (state_d == RESP);

        aw_idx_d = aw_hs ? bus.AWADDR[ADDR_WIDTH-1:2] : aw_idx_q;
        wdata_d  = w_hs ? bus.WDATA : wdata_q;
        wstrb_d  = w_hs ? bus.WSTRB : wstrb_q;

        bresp_d     = bresp_q;
        reg_wen_d   = 1'b0;
        reg_idx_d   = reg_idx_q;
        reg_wdata_d = reg_wdata_q;
        reg_wstrb_d = reg_wstrb_q;
        if (commit) begin
            bresp_d     = out_of_range ? RESP_SLVERR : RESP_OKAY;
            reg_wen_d   = !out_of_range && (eff_wstrb != '0);
            reg_idx_d   = eff_idx[IDX_W-1:0];
            reg_wdata_d = eff_wdata;
            reg_wstrb_d = eff_wstrb;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= IDLE;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= '0;
            aw_idx_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            reg_wen_q   <= 1'b0;
            reg_idx_q   <= '0;
            reg_wdata_q <= '0;
            reg_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            aw_idx_q    <= aw_idx_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            reg_wen_q   <= reg_wen_d;
            reg_idx_q   <= reg_idx_d;
            reg_wdata_q <= reg_wdata_d;
            reg_wstrb_q <= reg_wstrb_d;
        end
    end

    assign bus.AWREADY = awready_q;
    assign bus.WREADY  = wready_q;
    assign bus.BVALID  = bvalid_q;
    assign bus.BRESP   = bresp_q;
    assign REG_WEN     = reg_wen_q;
    assign REG_IDX     = reg_idx_q;
    assign REG_WDATA   = reg_wdata_q;
    assign REG_WSTRB   = reg_wstrb_q;

endmodule

// File: tb/tb_axi4_lite_slave_write.sv
// Directed testbench for axi4_lite_slave_write (ADDR_WIDTH=8, NUM_REGS=16).
// Inputs change on the falling edge; outputs are checked on the falling
// edge following the rising edge of interest.
module tb_axi4_lite_slave_write;

    logic        ACLK;
    logic        ARESETn;
    logic        REG_WEN;
    logic [3:0]  REG_IDX;
    logic [31:0] REG_WDATA;
    logic [3:0]  REG_WSTRB;

    int pass_cnt  = 0;
    int total_cnt = 0;

    axi4_lite_slave_write_if #(.ADDR_WIDTH(8)) bus ();

    axi4_lite_slave_write #(.ADDR_WIDTH(8), .NUM_REGS(16)) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .bus       (bus),
        .REG_WEN   (REG_WEN),
        .REG_IDX   (REG_IDX),
        .REG_WDATA (REG_WDATA),
        .REG_WSTRB (REG_WSTRB)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic drive_both(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bus.AWVALID = 1'b1; bus.AWADDR = addr;
        bus.WVALID  = 1'b1; bus.WDATA  = data; bus.WSTRB = strb;
    endtask

    task automatic drop_valids();
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        total_cnt++; if (bus.AWREADY !== 1'b0) $display("FAIL rst_awready: got %b want 0", bus.AWREADY); else pass_cnt++;
        total_cnt++; if (bus.WREADY !== 1'b0)  $display("FAIL rst_wready: got %b want 0", bus.WREADY); else pass_cnt++;
        total_cnt++; if (bus.BVALID !== 1'b0)  $display("FAIL rst_bvalid: got %b want 0", bus.BVALID); else pass_cnt++;
        total_cnt++; if (bus.BRESP !== 2'b00)  $display("FAIL rst_bresp: got %b want 00", bus.BRESP); else pass_cnt++;
        total_cnt++; if (REG_WEN !== 1'b0)     $display("FAIL rst_wen: got %b want 0", REG_WEN); else pass_cnt++;
        total_cnt++; if ({REG_IDX, REG_WDATA, REG_WSTRB} !== 40'h0)
            $display("FAIL rst_regbus: got %h want 0", {REG_IDX, REG_WDATA, REG_WSTRB}); else pass_cnt++;
        ARESETn = 1'b1;
        @(negedge ACLK);
        total_cnt++; if (bus.AWREADY !== 1'b1) $display("FAIL rel_awready: got %b want 1", bus.AWREADY); else pass_cnt++;
        total_cnt++; if (bus.WREADY !== 1'b1)  $display("FAIL rel_wready: got %b want 1", bus.WREADY); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        bus.BREADY = 1'b1;
        drive_both(8'h04, 32'hDEADBEEF, 4'hF);
        @(negedge ACLK);
        drop_valids();
        total_cnt++; if (REG_WEN !== 1'b1)            $display("FAIL sim_wen: got %b want 1", REG_WEN); else pass_cnt++;
        total_cnt++; if (REG_IDX !== 4'd1)            $display("FAIL sim_idx: got %0d want 1", REG_IDX); else pass_cnt++;
        total_cnt++; if (REG_WDATA !== 32'hDEADBEEF)  $display("FAIL sim_wdata: got %h want deadbeef", REG_WDATA); else pass_cnt++;
        total_cnt++; if (REG_WSTRB !== 4'hF)          $display("FAIL sim_wstrb: got %h want f", REG_WSTRB); else pass_cnt++;
        total_cnt++; if (bus.BVALID !== 1'b1)         $display("FAIL sim_bvalid: got %b want 1", bus.BVALID); else pass_cnt++;
        total_cnt++; if (bus.BRESP !== 2'b00)         $display("FAIL sim_bresp: got %b want 00", bus.BRESP); else pass_cnt++;
        total_cnt++; if ({bus.AWREADY, bus.WREADY} !== 2'b00)
            $display("FAIL sim_ready_low: got %b want 00", {bus.AWREADY, bus.WREADY}); else pass_cnt++;
        @(negedge ACLK);
        total_cnt++; if (bus.BVALID !== 1'b0)         $display("FAIL sim_bvalid_clr: got %b want 0", bus.BVALID); else pass_cnt++;
        total_cnt++; if ({bus.AWREADY, bus.WREADY} !== 2'b11)
            $display("FAIL sim_ready_back: got %b want 11", {bus.AWREADY, bus.WREADY}); else pass_cnt++;
        total_cnt++; if (REG_WEN !== 1'b0)            $display("FAIL sim_wen_pulse: got %b want 0", REG_WEN); else pass_cnt++;
        total_cnt++; if (REG_WDATA !== 32'hDEADBEEF)  $display("FAIL sim_wdata_hold: got %h want deadbeef", REG_WDATA); else pass_cnt++;
    endtask

    task automatic test_w_first();
        bus.WVALID = 1'b1; bus.WDATA = 32'h12345678; bus.WSTRB = 4'h3;
        @(negedge ACLK);
        bus.WVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total_cnt++; if ({bus.AWREADY, bus.WREADY, bus.BVALID, REG_WEN} !== 4'b1000)
                $display("FAIL wf_wait%0d: got aw/w/b/wen=%b want 1000", i, {bus.AWREADY, bus.WREADY, bus.BVALID, REG_WEN}); else pass_cnt++;
            if (i < 2) @(negedge ACLK);
        end
        bus.AWVALID = 1'b1; bus.AWADDR = 8'h0C;
        @(negedge ACLK);
        bus.AWVALID = 1'b0;
        total_cnt++; if (REG_WEN !== 1'b1)           $display("FAIL wf_wen: got %b want 1", REG_WEN); else pass_cnt++;
        total_cnt++; if (REG_IDX !== 4'd3)           $display("FAIL wf_idx: got %0d want 3", REG_IDX); else pass_cnt++;
        total_cnt++; if (REG_WSTRB !== 4'h3)         $display("FAIL wf_wstrb: got %h want 3", REG_WSTRB); else pass_cnt++;
        total_cnt++; if (REG_WDATA !== 32'h12345678) $display("FAIL wf_wdata: got %h want 12345678", REG_WDATA); else pass_cnt++;
        total_cnt++; if ({bus.BVALID, bus.BRESP} !== 3'b100)
            $display("FAIL wf_resp: got bvalid/bresp=%b want 100", {bus.BVALID, bus.BRESP}); else pass_cnt++;
        @(negedge ACLK);
        total_cnt++; if (bus.BVALID !== 1'b0)        $display("FAIL wf_bvalid_clr: got %b want 0", bus.BVALID); else pass_cnt++;
    endtask

    task automatic test_range();
        // Highest in-range word (index 15).
        drive_both(8'h3C, 32'h0000FFFF, 4'hF);
        @(negedge ACLK);
        drop_valids();
        total_cnt++; if ({REG_WEN, REG_IDX} !== 5'b1_1111)
            $display("FAIL top_wen_idx: got wen=%b idx=%0d want wen=1 idx=15", REG_WEN, REG_IDX); else pass_cnt++;
        total_cnt++; if (bus.BRESP !== 2'b00) $display("FAIL top_bresp: got %b want 00", bus.BRESP); else pass_cnt++;
        @(negedge ACLK);
        // First out-of-range word (index 16).
        drive_both(8'h40, 32'h55555555, 4'hF);
        @(negedge ACLK);
        drop_valids();
        total_cnt++; if (bus.BVALID !== 1'b1) $display("FAIL oor_bvalid: got %b want 1", bus.BVALID); else pass_cnt++;
        total_cnt++; if (bus.BRESP !== 2'b10) $display("FAIL oor_bresp: got %b want 10", bus.BRESP); else pass_cnt++;
        total_cnt++; if (REG_WEN !== 1'b0)    $display("FAIL oor_wen: got %b want 0", REG_WEN); else pass_cnt++;
        @(negedge ACLK);
        total_cnt++; if ({bus.BVALID, REG_WEN} !== 2'b00)
            $display("FAIL oor_after: got bvalid/wen=%b want 00", {bus.BVALID, REG_WEN}); else pass_cnt++;
    endtask

    task automatic test_bready_stall();
        bus.BREADY = 1'b0;
        drive_both(8'h08, 32'hA5A5A5A5, 4'hF);
        @(negedge ACLK);
        total_cnt++; if ({bus.BVALID, bus.BRESP, REG_WEN} !== 4'b1001)
            $display("FAIL st_commit: got bvalid/bresp/wen=%b want 1001", {bus.BVALID, bus.BRESP, REG_WEN}); else pass_cnt++;
        drive_both(8'h10, 32'h11112222, 4'hC);
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            total_cnt++; if ({bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY, REG_WEN} !== 6'b100000)
                $display("FAIL st_hold%0d: got b/resp/aw/w/wen=%b want 100000", i,
                         {bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY, REG_WEN}); else pass_cnt++;
            total_cnt++; if (REG_WDATA !== 32'hA5A5A5A5)
                $display("FAIL st_data%0d: got %h want a5a5a5a5", i, REG_WDATA); else pass_cnt++;
        end
        bus.BREADY = 1'b1;
        @(negedge ACLK);
        total_cnt++; if ({bus.BVALID, bus.AWREADY, bus.WREADY, REG_WEN} !== 4'b0110)
            $display("FAIL st_idle: got b/aw/w/wen=%b want 0110", {bus.BVALID, bus.AWREADY, bus.WREADY, REG_WEN}); else pass_cnt++;
        @(negedge ACLK);
        drop_valids();
        total_cnt++; if ({REG_WEN, REG_IDX, REG_WSTRB} !== 9'b1_0100_1100)
            $display("FAIL st_new: got wen=%b idx=%0d strb=%h want 1/4/c", REG_WEN, REG_IDX, REG_WSTRB); else pass_cnt++;
        total_cnt++; if (REG_WDATA !== 32'h11112222) $display("FAIL st_new_data: got %h want 11112222", REG_WDATA); else pass_cnt++;
        @(negedge ACLK);
    endtask

    task automatic test_reset_mid_zero_strb();
        bus.AWVALID = 1'b1; bus.AWADDR = 8'h08;
        @(negedge ACLK);
        bus.AWVALID = 1'b0;
        total_cnt++; if ({bus.AWREADY, bus.WREADY} !== 2'b01)
            $display("FAIL mr_have_aw: got aw/w=%b want 01", {bus.AWREADY, bus.WREADY}); else pass_cnt++;
        ARESETn = 1'b0;
        #1;
        total_cnt++; if ({bus.AWREADY, bus.WREADY, bus.BVALID, REG_WEN} !== 4'b0000)
            $display("FAIL mr_async: got aw/w/b/wen=%b want 0000", {bus.AWREADY, bus.WREADY, bus.BVALID, REG_WEN}); else pass_cnt++;
        total_cnt++; if (REG_WDATA !== 32'h0) $display("FAIL mr_wdata_clr: got %h want 0", REG_WDATA); else pass_cnt++;
        @(negedge ACLK);
        ARESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            total_cnt++; if ({bus.AWREADY, bus.WREADY, bus.BVALID, REG_WEN} !== 4'b1100)
                $display("FAIL mr_idle%0d: got aw/w/b/wen=%b want 1100", i, {bus.AWREADY, bus.WREADY, bus.BVALID, REG_WEN}); else pass_cnt++;
        end
        drive_both(8'h14, 32'hCAFEF00D, 4'h0);
        @(negedge ACLK);
        drop_valids();
        total_cnt++; if ({bus.BVALID, bus.BRESP} !== 3'b100)
            $display("FAIL zs_resp: got bvalid/bresp=%b want 100", {bus.BVALID, bus.BRESP}); else pass_cnt++;
        total_cnt++; if (REG_WEN !== 1'b0) $display("FAIL zs_wen: got %b want 0", REG_WEN); else pass_cnt++;
        @(negedge ACLK);
        total_cnt++; if ({bus.BVALID, REG_WEN} !== 2'b00)
            $display("FAIL zs_after: got bvalid/wen=%b want 00", {bus.BVALID, REG_WEN}); else pass_cnt++;
    endtask

    initial begin
        ARESETn     = 1'b0;
        bus.AWVALID = 1'b0;
        bus.AWADDR  = '0;
        bus.AWPROT  = 3'b010;
        bus.WVALID  = 1'b0;
        bus.WDATA   = '0;
        bus.WSTRB   = '0;
        bus.BREADY  = 1'b0;
        @(negedge ACLK);
        test_reset();
        test_simultaneous();
        test_w_first();
        test_range();
        test_bready_stall();
        test_reset_mid_zero_strb();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
